aes_key_sched_ctrl: RTL

- Controller that sequences the AES key-expansion unit and owns the round-key store.
- Accepts key-load requests from the AXI4-Lite register side, pulses the expander start, and captures each emitted subkey into a 15-entry round-key memory with per-entry valid bits.
- Serves round-key reads from the cipher core, stalling a read until its entry is valid.
- Suppresses re-expansion when the same key and length are reloaded.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_rk_mem.sv | 68 ++++++
 rtl/aes_key_sched_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule controller and its round-key store.
//   - Key-length codes as carried on req_key_len / exp_key_len.
//   - Round counts per key length and the derived round-key entry count.
//   - Controller state encoding (also exported on the debug state output).
package aes_pkg;

  localparam logic [1:0] KL_NONE = 2'b00;
  localparam logic [1:0] KL_128  = 2'b01;
  localparam logic [1:0] KL_192  = 2'b10;
  localparam logic [1:0] KL_256  = 2'b11;

  localparam logic [3:0] ROUNDS_128 = 4'd10;
  localparam logic [3:0] ROUNDS_192 = 4'd12;
  localparam logic [3:0] ROUNDS_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    EXPAND = 2'd2,
    READY  = 2'd3
  } aes_state_e;

  // Rounds for a key-length code; 0 for the invalid code.
  function automatic logic [3:0] rounds_for(input logic [1:0] len);
    logic [3:0] r;
    case (len)
      KL_128:  r = ROUNDS_128;
      KL_192:  r = ROUNDS_192;
      KL_256:  r = ROUNDS_256;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  // Number of round-key entries (rounds + 1); 0 for the invalid code.
  function automatic logic [3:0] nkeys(input logic [1:0] len);
    return (len == KL_NONE) ? 4'd0 : rounds_for(len) + 4'd1;
  endfunction

endpackage

// File: rtl/aes_rk_mem.sv
// Round-key register file with per-entry valid bits.
//   clk, reset    : clock, synchronous active-high reset (clears valid bits and read port)
//   i_clr         : clear every valid bit (new key accepted)
//   i_we/i_waddr/i_wdata : subkey write port; out-of-range addresses are ignored
//   i_rd_req/i_raddr     : read request (level) and entry index
//   o_rd_valid/o_rd_data : registered read result, one cycle after a request that hits
//   o_valid       : current valid-bit vector
module aes_rk_mem
  import aes_pkg::*;
#(
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [3:0]       i_waddr,
  input  logic [127:0]     i_wdata,
  input  logic             i_rd_req,
  input  logic [3:0]       i_raddr,
  output logic             o_rd_valid,
  output logic [127:0]     o_rd_data,
  output logic [DEPTH-1:0] o_valid
);

  localparam logic [3:0] DEPTH_A = 4'(DEPTH);

  logic [127:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic             r_rd_valid;
  logic [127:0]     r_rd_data;

  logic w_waddr_ok;
  logic w_raddr_ok;
  logic w_wr;
  logic w_bypass;
  logic w_hit;

  assign w_waddr_ok = (i_waddr < DEPTH_A);
  assign w_raddr_ok = (i_raddr < DEPTH_A);
  assign w_wr       = i_we && w_waddr_ok;
  // A write to the entry being read lands in rk_data on the next cycle.
  assign w_bypass   = w_wr && (i_waddr == i_raddr);
  // A clear in this cycle invalidates everything, so a pending read stalls at once.
  assign w_hit      = i_rd_req && !i_clr && w_raddr_ok && (r_valid[i_raddr] || w_bypass);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (i_clr) r_valid <= '0;
      else if (w_wr) r_valid[i_waddr] <= 1'b1;
      r_rd_valid <= w_hit;
      if (w_hit) r_rd_data <= w_bypass ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_valid    = r_valid;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: sequences the key-expansion unit and owns the
// round-key store.
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_key/req_key_len : key-load request from the register side
//   exp_start/exp_key/exp_key_len   : start pulse and registered key to the expander
//   exp_valid/exp_waddr/exp_subkey  : subkeys emitted by the expander
//   rk_req/rk_addr/rk_valid/rk_data : round-key read port for the cipher core
//   keys_ready, num_rounds, busy, err : status
//   dbg_state                       : current controller state (aes_state_e encoding)
//
// Handshake: a request transfers on a cycle where req_valid && req_ready are both
// high. req_ready depends only on state (IDLE/READY, not in reset), never on
// req_valid. The expander side has no backpressure: every exp_valid cycle during
// expansion is consumed. rk_req is a level held by the core until rk_valid.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NKEYS   = 15,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [255:0] req_key,
  input  logic [1:0]   req_key_len,
  output logic         exp_start,
  output logic [255:0] exp_key,
  output logic [1:0]   exp_key_len,
  input  logic         exp_valid,
  input  logic [3:0]   exp_waddr,
  input  logic [127:0] exp_subkey,
  input  logic         rk_req,
  input  logic [3:0]   rk_addr,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         keys_ready,
  output logic [3:0]   num_rounds,
  output logic         busy,
  output logic         err,
  output logic [1:0]   dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  aes_state_e       r_state;
  aes_state_e       w_state_next;
  logic [255:0]     r_key;
  logic [1:0]       r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [3:0]       w_n;
  logic [3:0]       w_last;
  logic [NKEYS-1:0] w_valid;
  logic             w_expand;
  logic             w_we;
  logic             w_wr_oob;
  logic             w_last_done;
  logic             w_timeout;
  logic             w_req;
  logic             w_accept_ok;
  logic             w_bad_len;
  logic             w_same;
  logic             w_load;

  assign w_n      = nkeys(r_len);
  assign w_last   = w_n - 4'd1;
  assign w_expand = (r_state == EXPAND);

  // Expander writes: only in EXPAND; indices beyond the current length are dropped.
  assign w_we     = w_expand && exp_valid && (exp_waddr < w_n);
  assign w_wr_oob = w_expand && exp_valid && !(exp_waddr < w_n);

  // Final entry present, counting a write of it in this very cycle.
  assign w_last_done = w_valid[w_last] || (w_we && (exp_waddr == w_last));

  // The counter reaches zero on the edge that returns the FSM to IDLE,
  // TIMEOUT cycles after the start pulse. Completion wins a tie.
  assign w_timeout = w_expand && !w_last_done && (r_cnt == CNT_W'(1));

  assign w_req       = req_valid && req_ready;
  assign w_accept_ok = w_req && (req_key_len != KL_NONE);
  assign w_bad_len   = w_req && (req_key_len == KL_NONE);
  // Reloading the stored key in READY is acknowledged without re-expanding.
  assign w_same      = (r_state == READY) && (req_key == r_key) && (req_key_len == r_len);
  assign w_load      = w_accept_ok && !w_same;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_next = START;
      READY:   if (w_load) w_state_next = START;
      START:   w_state_next = EXPAND;
      EXPAND: begin
        if (w_last_done)    w_state_next = READY;
        else if (w_timeout) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_len   <= KL_NONE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_key <= req_key;
        r_len <= req_key_len;
      end
      if (r_state == START) r_cnt <= CNT_W'(TIMEOUT - 1);
      else if (w_expand && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
      if (w_accept_ok) r_err <= 1'b0;
      else if (w_bad_len || w_wr_oob || w_timeout) r_err <= 1'b1;
    end
  end

  aes_rk_mem #(
    .DEPTH(NKEYS)
  ) u_rk_mem (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_load),
    .i_we       (w_we),
    .i_waddr    (exp_waddr),
    .i_wdata    (exp_subkey),
    .i_rd_req   (rk_req),
    .i_raddr    (rk_addr),
    .o_rd_valid (rk_valid),
    .o_rd_data  (rk_data),
    .o_valid    (w_valid)
  );

  // Gated by reset so no request is taken while the controller is held in reset.
  assign req_ready   = !reset && ((r_state == IDLE) || (r_state == READY));
  assign exp_start   = (r_state == START);
  assign busy        = (r_state == START) || w_expand;
  assign keys_ready  = (r_state == READY);
  assign exp_key     = r_key;
  assign exp_key_len = r_len;
  assign num_rounds  = rounds_for(r_len);
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule
